// File: rtl/framebuffer_scaled_reader_if.sv
// Display-timing in / framebuffer-read out bundle for framebuffer_scaled_reader.
// master = timing source and read consumer, slave = the reader itself.
interface framebuffer_scaled_reader_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              i_hblank;
    logic              i_vblank;
    logic              i_hsync;
    logic              i_vsync;
    logic              i_vde;
    logic [1:0]        i_scale;
    logic [ADDR_W-1:0] o_read_address;
    logic              o_read_enable;
    logic              o_hsync;
    logic              o_vsync;
    logic              o_vde;
    logic              o_border;
    logic              o_frame_start;

    modport master (
        output i_hblank, i_vblank, i_hsync, i_vsync, i_vde, i_scale,
        input  o_read_address, o_read_enable, o_hsync, o_vsync, o_vde, o_border, o_frame_start
    );

    modport slave (
        input  i_hblank, i_vblank, i_hsync, i_vsync, i_vde, i_scale,
        output o_read_address, o_read_enable, o_hsync, o_vsync, o_vde, o_border, o_frame_start
    );
endinterface

// File: rtl/framebuffer_scaled_reader.sv
// Framebuffer read-address generator with a positionable window and 1x-4x pixel replication;
// sync/DE/border are delayed to line up with the RAM read data.
module framebuffer_scaled_reader #(
    parameter int unsigned FB_H        = 480,
    parameter int unsigned FB_V        = 320,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned H_OFFSET    = 0,
    parameter int unsigned V_OFFSET    = 0,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    framebuffer_scaled_reader_if.slave   bus
);
    localparam int unsigned X_W    = 11;
    localparam int unsigned Y_W    = 10;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned DLY    = 1 + RAM_LATENCY;
    localparam int unsigned PIPE_W = 5;
    localparam logic [PIPE_W-1:0] PIPE_RST = 5'b11000;

    typedef enum logic [1:0] {IDLE, LINE, HOLD} state_t;

    state_t             state, state_next;
    logic               hblank_q, vblank_q, armed, line_seen, de_pending;
    logic [X_W-1:0]     x_reg, x_cur;
    logic [Y_W-1:0]     y_reg, y_cur;
    logic [1:0]         scale_m1;
    logic [X_W-1:0]     col;
    logic [1:0]         sub_x, sub_y;
    logic [ADDR_W-1:0]  row_base;
    logic [WIN_W-1:0]   h_span, v_span;
    logic               hblank_fall, vblank_fall, vblank_rise, armed_now;
    logic               in_h, in_v, in_win, line_done;
    logic [ADDR_W-1:0]  read_address;
    logic               read_enable;
    logic [PIPE_W-1:0]  pipe [DLY];

    assign hblank_fall = hblank_q & ~bus.i_hblank;
    assign vblank_fall = vblank_q & ~bus.i_vblank;
    assign vblank_rise = ~vblank_q & bus.i_vblank;
    assign armed_now   = armed | vblank_fall;

    // Position of the current input cycle; a new line starts at the hblank falling edge
    always_comb begin
        x_cur = hblank_fall ? '0 : x_reg;
        y_cur = y_reg;
        if (hblank_fall && !bus.i_vblank)
            y_cur = !line_seen ? '0 : ((y_reg == '1) ? y_reg : y_reg + Y_W'(1));
    end

    always_comb begin
        h_span = WIN_W'(FB_H);
        v_span = WIN_W'(FB_V);
        case (scale_m1)
            2'd1:    begin h_span = WIN_W'(2 * FB_H); v_span = WIN_W'(2 * FB_V); end
            2'd2:    begin h_span = WIN_W'(3 * FB_H); v_span = WIN_W'(3 * FB_V); end
            2'd3:    begin h_span = WIN_W'(4 * FB_H); v_span = WIN_W'(4 * FB_V); end
            default: ;
        endcase
    end

    // Offsets below the window wrap to huge values, so one unsigned compare covers both bounds
    assign in_h   = (WIN_W'(x_cur) - WIN_W'(H_OFFSET)) < h_span;
    assign in_v   = (WIN_W'(y_cur) - WIN_W'(V_OFFSET)) < v_span;
    assign in_win = armed_now & ~bus.i_hblank & ~bus.i_vblank & in_h & in_v;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hblank_q   <= 1'b0;
            vblank_q   <= 1'b0;
            armed      <= 1'b0;
            scale_m1   <= 2'd0;
            x_reg      <= '0;
            y_reg      <= '0;
            line_seen  <= 1'b0;
            de_pending <= 1'b0;
        end else begin
            hblank_q <= bus.i_hblank;
            vblank_q <= bus.i_vblank;
            if (vblank_fall) armed    <= 1'b1;
            if (vblank_rise) scale_m1 <= bus.i_scale;
            if (!bus.i_hblank) x_reg <= (x_cur == '1) ? x_cur : x_cur + X_W'(1);
            if (bus.i_vblank) begin
                y_reg     <= '0;
                line_seen <= 1'b0;
            end else if (hblank_fall) begin
                y_reg     <= y_cur;
                line_seen <= 1'b1;
            end
            if (bus.i_vblank)   de_pending <= 1'b1;
            else if (bus.i_vde) de_pending <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Leaving LINE without vblank marks the end of one window line
    always_comb begin
        state_next = state;
        line_done  = 1'b0;
        case (state)
            IDLE: if (!bus.i_vblank) state_next = in_win ? LINE : HOLD;
            LINE: begin
                if (bus.i_vblank) state_next = IDLE;
                else if (!in_win) begin
                    state_next = HOLD;
                    line_done  = 1'b1;
                end
            end
            HOLD: begin
                if (bus.i_vblank) state_next = IDLE;
                else if (in_win)  state_next = LINE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Replication by sub-counters: col steps every S pixels, row_base every S window lines
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_vblank) begin
            row_base <= '0;
            col      <= '0;
            sub_x    <= 2'd0;
            sub_y    <= 2'd0;
        end else if (line_done) begin
            col   <= '0;
            sub_x <= 2'd0;
            if (sub_y == scale_m1) begin
                sub_y    <= 2'd0;
                row_base <= row_base + ADDR_W'(FB_H);
            end else begin
                sub_y <= sub_y + 2'd1;
            end
        end else if (in_win) begin
            if (sub_x == scale_m1) begin
                sub_x <= 2'd0;
                col   <= col + X_W'(1);
            end else begin
                sub_x <= sub_x + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            read_address <= '0;
            read_enable  <= 1'b0;
        end else begin
            read_address <= armed_now ? row_base + ADDR_W'(col) : '0;
            read_enable  <= in_win;
        end
    end

    // {hsync, vsync, vde, border, frame_start} delayed by 1+RAM_LATENCY
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DLY; i++) pipe[i] <= PIPE_RST;
        end else begin
            pipe[0] <= {bus.i_hsync, bus.i_vsync, bus.i_vde,
                        armed_now & bus.i_vde & ~in_win,
                        de_pending & bus.i_vde & ~bus.i_vblank};
            for (int unsigned i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.o_read_address = read_address;
    assign bus.o_read_enable  = read_enable;
    assign bus.o_hsync        = pipe[DLY-1][4];
    assign bus.o_vsync        = pipe[DLY-1][3];
    assign bus.o_vde          = pipe[DLY-1][2];
    assign bus.o_border       = pipe[DLY-1][1];
    assign bus.o_frame_start  = pipe[DLY-1][0];
endmodule
